// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register with jump/branch redirect, IF/ID pipeline
// register with stall and flush, and saturating fetch/flush performance counters.
module if_fetch_stage #(
  parameter logic [9:0] RESET_PC = 10'd0,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Data_Hazard,
  input  logic             IF_Flush,
  input  logic             jump,
  input  logic [9:0]       jump_address,
  input  logic             branch_taken,
  input  logic [9:0]       branch_address,
  input  logic [31:0]      imem_rdata,
  output logic [7:0]       imem_addr,
  output logic [9:0]       pc,
  output logic [9:0]       if_id_pc_plus4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] flush_count
);

  // Handshake: if_id_valid qualifies if_id_instr/if_id_pc_plus4 every cycle; there is
  // no ready, Data_Hazard=0 is the backpressure (hold) and IF_Flush inserts a bubble.

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [9:0]       ALIGN   = 10'h3FC;

  logic [9:0] pc_plus4;
  logic [9:0] next_pc;

  assign imem_addr = pc[9:2];

  always_comb begin
    pc_plus4 = pc + 10'd4;
    next_pc  = pc_plus4;
    if (!Data_Hazard)
      next_pc = pc;
    else if (jump)
      next_pc = jump_address & ALIGN;
    else if (branch_taken)
      next_pc = branch_address & ALIGN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC & ALIGN;
      if_id_pc_plus4 <= 10'd0;
      if_id_instr    <= 32'd0;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
      flush_count    <= '0;
    end else begin
      pc <= next_pc;
      // Flush wins over stall: the squashed slot is always overwritten with a bubble.
      if (IF_Flush) begin
        if_id_pc_plus4 <= pc_plus4;
        if_id_instr    <= 32'd0;
        if_id_valid    <= 1'b0;
        if (flush_count != CNT_MAX)
          flush_count <= flush_count + CNT_ONE;
      end else if (Data_Hazard) begin
        if_id_pc_plus4 <= pc_plus4;
        if_id_instr    <= imem_rdata;
        if_id_valid    <= 1'b1;
        if (fetch_count != CNT_MAX)
          fetch_count <= fetch_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: driver pushes hand-computed post-edge state into
// a queue, monitor pops and compares after each rising edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Data_Hazard;
  logic        IF_Flush;
  logic        jump;
  logic [9:0]  jump_address;
  logic        branch_taken;
  logic [9:0]  branch_address;

  logic [7:0]  imem_addr, s_imem_addr;
  logic [31:0] imem_rdata, s_imem_rdata;
  logic [9:0]  pc, s_pc;
  logic [9:0]  if_id_pc_plus4, s_if_id_pc_plus4;
  logic [31:0] if_id_instr, s_if_id_instr;
  logic        if_id_valid, s_if_id_valid;
  logic [15:0] fetch_count, flush_count;
  logic [3:0]  s_fetch_count, s_flush_count;

  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] instr;
    logic [9:0]  pp4;
    logic        valid;
    logic [15:0] fc;
    logic [15:0] flc;
    logic [3:0]  fc4;
    logic [3:0]  flc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  // Instruction memory: word at address a is a*0x11.
  assign imem_rdata   = 32'(imem_addr) * 32'h11;
  assign s_imem_rdata = 32'(s_imem_addr) * 32'h11;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .Data_Hazard(Data_Hazard), .IF_Flush(IF_Flush),
    .jump(jump), .jump_address(jump_address), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .pc(pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count), .flush_count(flush_count)
  );

  if_fetch_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .Data_Hazard(Data_Hazard), .IF_Flush(IF_Flush),
    .jump(jump), .jump_address(jump_address), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_rdata(s_imem_rdata), .imem_addr(s_imem_addr),
    .pc(s_pc), .if_id_pc_plus4(s_if_id_pc_plus4), .if_id_instr(s_if_id_instr),
    .if_id_valid(s_if_id_valid), .fetch_count(s_fetch_count), .flush_count(s_flush_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: apply inputs, record the expected state after the next rising edge.
  task automatic step(input logic rst, input logic dh, input logic fl,
                      input logic j, input logic [9:0] ja,
                      input logic b, input logic [9:0] ba,
                      input logic [9:0] e_pc, input logic [31:0] e_instr,
                      input logic [9:0] e_pp4, input logic e_v,
                      input int e_fc, input int e_flc, input int e_fc4, input int e_flc4);
    exp_t e;
    reset = rst; Data_Hazard = dh; IF_Flush = fl;
    jump = j; jump_address = ja; branch_taken = b; branch_address = ba;
    e.pc = e_pc; e.instr = e_instr; e.pp4 = e_pp4; e.valid = e_v;
    e.fc = 16'(e_fc); e.flc = 16'(e_flc); e.fc4 = 4'(e_fc4); e.flc4 = 4'(e_flc4);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",          32'(pc),             32'(e.pc));
        chk("imem_addr",   32'(imem_addr),      32'(e.pc[9:2]));
        chk("if_id_instr", if_id_instr,         e.instr);
        chk("if_id_pp4",   32'(if_id_pc_plus4), 32'(e.pp4));
        chk("if_id_valid", 32'(if_id_valid),    32'(e.valid));
        chk("fetch_count", 32'(fetch_count),    32'(e.fc));
        chk("flush_count", 32'(flush_count),    32'(e.flc));
        chk("s_pc",        32'(s_pc),           32'(e.pc));
        chk("s_imem_addr", 32'(s_imem_addr),    32'(e.pc[9:2]));
        chk("s_instr",     s_if_id_instr,       e.instr);
        chk("s_pp4",       32'(s_if_id_pc_plus4), 32'(e.pp4));
        chk("s_valid",     32'(s_if_id_valid),  32'(e.valid));
        chk("s_fetch_cnt", 32'(s_fetch_count),  32'(e.fc4));
        chk("s_flush_cnt", 32'(s_flush_count),  32'(e.flc4));
      end
    end
  end

  initial begin : driver
    int budget;
    // Reset overriding stall-off, flush and jump.
    step(1, 1, 1, 1, 10'h3F0, 1, 10'h200, 10'h000, 32'h0, 10'h000, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 10'h000, 0, 10'h000, 10'h000, 32'h0, 10'h000, 0, 0, 0, 0, 0);
    // Sequential fetch.
    step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'h004, 32'h00, 10'h004, 1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'h008, 32'h11, 10'h008, 1, 2, 0, 2, 0);
    // Stall at pc=8 for two cycles, jump request ignored while stalled.
    step(0, 0, 0, 0, 10'h000, 0, 10'h000, 10'h008, 32'h11, 10'h008, 1, 2, 0, 2, 0);
    step(0, 0, 0, 1, 10'h100, 0, 10'h000, 10'h008, 32'h11, 10'h008, 1, 2, 0, 2, 0);
    step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'h00C, 32'h22, 10'h00C, 1, 3, 0, 3, 0);
    step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'h010, 32'h33, 10'h010, 1, 4, 0, 4, 0);
    // Branch with flush.
    step(0, 1, 1, 0, 10'h000, 1, 10'h100, 10'h100, 32'h0, 10'h014, 0, 4, 1, 4, 1);
    step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'h104, 32'h440, 10'h104, 1, 5, 1, 5, 1);
    // Jump and branch together: jump wins.
    step(0, 1, 0, 1, 10'h040, 1, 10'h200, 10'h040, 32'h451, 10'h108, 1, 6, 1, 6, 1);
    // Misaligned jump to the last word, then wrap past 1020.
    step(0, 1, 0, 1, 10'h3FF, 0, 10'h000, 10'h3FC, 32'h110, 10'h044, 1, 7, 1, 7, 1);
    step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'h000, 32'h10EF, 10'h000, 1, 8, 1, 8, 1);
    step(0, 1, 0, 1, 10'h043, 0, 10'h000, 10'h040, 32'h0, 10'h004, 1, 9, 1, 9, 1);
    // Flush while stalled: PC holds, bubble enters IF/ID.
    step(0, 0, 1, 0, 10'h000, 0, 10'h000, 10'h040, 32'h0, 10'h044, 0, 9, 2, 9, 2);
    // Fetches until the 4-bit fetch counter saturates.
    for (int i = 0; i < 7; i++)
      step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'(32'h44 + 4 * i),
           (32'h10 + 32'(i)) * 32'h11, 10'(32'h44 + 4 * i), 1, 10 + i, 2,
           (10 + i > 15) ? 15 : 10 + i, 2);
    // Flushes until the 4-bit flush counter saturates.
    for (int i = 0; i < 14; i++)
      step(0, 1, 1, 0, 10'h000, 0, 10'h000, 10'(32'h60 + 4 * i), 32'h0,
           10'(32'h60 + 4 * i), 0, 16, 3 + i, 15, (3 + i > 15) ? 15 : 3 + i);
    // Reset mid-stall with flush and jump asserted, then first fetch at RESET_PC.
    step(1, 0, 1, 1, 10'h080, 0, 10'h000, 10'h000, 32'h0, 10'h000, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'h004, 32'h0, 10'h004, 1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 10'h000, 0, 10'h000, 10'h008, 32'h11, 10'h008, 1, 2, 0, 2, 0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
